exc_prio_trap_unit: RTL

- Parametrised successor to the fixed 12-level exception encoder.
- Latches exception and interrupt requests from NUM_SRC sources into per-source pending slots, each with its own captured EPC and TVAL.
- Selects the highest-priority eligible source (index 0 highest), presents one trap to the fetch stage over a valid/ready handshake, and drives the machine-mode trap CSRs.
- Tracks in-handler state until mret, and counts requests dropped on already-pending sources.

---
 rtl/exc_prio_trap_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exc_prio_trap_unit.sv
// Priority trap unit: per-source pending slots with captured EPC/TVAL, fixed-priority
// arbitration, valid/ready redirect to fetch and machine-mode trap CSR state.
module exc_prio_trap_unit #(
    parameter int                  NUM_SRC  = 12,
    parameter int                  XLEN     = 32,
    parameter logic [NUM_SRC-1:0]  INT_MASK = '0,
    parameter int                  DROP_W   = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_SRC-1:0]      req_in,
    input  logic [NUM_SRC*XLEN-1:0] pc_in,
    input  logic [NUM_SRC*XLEN-1:0] tval_in,
    input  logic [XLEN-1:0]         mtvec_in,
    input  logic                    trap_ready_in,
    input  logic                    mret_in,
    output logic                    trap_valid_out,
    output logic [XLEN-1:0]         trap_pc_out,
    output logic [XLEN-1:0]         mepc_out,
    output logic [XLEN-1:0]         mtval_out,
    output logic [XLEN-1:0]         mcause_out,
    output logic [XLEN-1:0]         mstatus_out,
    output logic [NUM_SRC-1:0]      pending_out,
    output logic [DROP_W-1:0]       drop_cnt_out
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    typedef enum logic [1:0] {IDLE, TRAP, HANDLER} state_t;
    state_t state_q, state_n;

    logic [NUM_SRC-1:0]           pending, clr, cap, pending_n;
    logic [NUM_SRC-1:0][XLEN-1:0] slot_pc, slot_tval;
    logic [IDX_W-1:0]             win_idx, win_q;
    logic                         any_elig, mie, mpie;
    logic                         take, accept, ret;
    logic [CNT_W-1:0]             n_drop;
    logic [SUM_W-1:0]             drop_sum;
    logic [XLEN-1:0]              tpc_n, cause_n;

    // Lowest-index eligible source wins; interrupts need MIE.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (pending[k] && (!INT_MASK[k] || mie)) begin
                any_elig = 1'b1;
                win_idx  = k[IDX_W-1:0];
            end
        end
    end

    assign take   = (state_q == IDLE) && any_elig;
    assign accept = (state_q == TRAP) && trap_ready_in;
    assign ret    = (state_q == HANDLER) && mret_in;

    // A slot cleared this cycle is free to capture a same-cycle request.
    always_comb begin
        clr    = '0;
        cap    = '0;
        n_drop = '0;
        if (accept) clr[win_q] = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (req_in[k]) begin
                if (!pending[k] || clr[k]) cap[k] = 1'b1;
                else                       n_drop = n_drop + CNT_W'(1);
            end
        end
        pending_n = (pending & ~clr) | req_in;
        drop_sum  = SUM_W'(drop_cnt_out) + SUM_W'(n_drop);
    end

    always_comb begin
        tpc_n = {mtvec_in[XLEN-1:2], 2'b00};
        if (mtvec_in[1:0] == 2'b01 && INT_MASK[win_idx])
            tpc_n = tpc_n + (XLEN'(win_idx) << 2);
        cause_n = '0;
        cause_n[IDX_W-1:0] = win_idx;
        cause_n[XLEN-1] = INT_MASK[win_idx];
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (any_elig)      state_n = TRAP;
            TRAP:    if (trap_ready_in) state_n = HANDLER;
            HANDLER: if (mret_in)       state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            pending        <= '0;
            drop_cnt_out   <= '0;
            win_q          <= '0;
            mie            <= 1'b1;
            mpie           <= 1'b0;
            trap_valid_out <= 1'b0;
            trap_pc_out    <= '0;
            mepc_out       <= '0;
            mtval_out      <= '0;
            mcause_out     <= '0;
        end else begin
            state_q <= state_n;
            pending <= pending_n;
            if (drop_sum[SUM_W-1:DROP_W] != '0) drop_cnt_out <= '1;
            else                                drop_cnt_out <= drop_sum[DROP_W-1:0];
            if (take) begin
                win_q          <= win_idx;
                trap_valid_out <= 1'b1;
                trap_pc_out    <= tpc_n;
                mepc_out       <= slot_pc[win_idx];
                mtval_out      <= slot_tval[win_idx];
                mcause_out     <= cause_n;
            end
            if (accept) begin
                trap_valid_out <= 1'b0;
                mpie           <= mie;
                mie            <= 1'b0;
            end
            if (ret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    // Slot payloads are only meaningful while pending, so they need no reset.
    always_ff @(posedge clk_in) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cap[k]) begin
                slot_pc[k]   <= pc_in[k*XLEN +: XLEN];
                slot_tval[k] <= tval_in[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        mstatus_out        = '0;
        mstatus_out[3]     = mie;
        mstatus_out[7]     = mpie;
        mstatus_out[12:11] = 2'b11;
    end

    assign pending_out = pending;
endmodule
